// File: rtl/svc_pkg.sv
// Shared types and constants for the status vector controller.
package svc_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } svc_state_e;

    localparam int unsigned SVC_DEPTH_DEFAULT = 16;

    function automatic int unsigned svc_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/svc_occupancy_counter.sv
// Saturating occupancy counter with empty/full decode and the one-edge-delayed
// expected-full flag used to cross-check the downstream vector.
module svc_occupancy_counter
    import svc_pkg::*;
#(
    parameter  int unsigned DEPTH = SVC_DEPTH_DEFAULT,
    localparam int unsigned CNT_W = svc_cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             exp_full_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             exp_full_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != MAX_CNT)) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            count_q    <= '0;
            exp_full_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            exp_full_q <= (count_q == MAX_CNT);
        end
    end

    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == MAX_CNT);
    assign exp_full_o = exp_full_q;

endmodule

// File: rtl/status_vector_ctrl.sv
// Allocate/retire handshake front-end for the status valid vector.
// Optional drain sequencer enabled by defining SVC_FLUSH_EN.
module status_vector_ctrl
    import svc_pkg::*;
#(
    parameter  int unsigned DEPTH = SVC_DEPTH_DEFAULT,
    localparam int unsigned CNT_W = svc_cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             alloc_valid_i,
    input  logic             alloc_value_i,
    output logic             alloc_ready_o,
    input  logic             retire_req_i,
    output logic             retire_ack_o,
`ifdef SVC_FLUSH_EN
    input  logic             flush_i,
`endif
    input  logic             full_i,
    output logic             push_o,
    output logic             pull_o,
    output logic             value_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             busy_o,
    output logic             err_o
);

    svc_state_e       state_q;
    svc_state_e       state_d;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             exp_full;
    logic             alloc_acc;
    logic             retire_acc;
    logic             flush_pull;
    logic             push_q;
    logic             pull_q;
    logic             value_q;
    logic             ack_q;
    logic             err_q;

    svc_occupancy_counter #(
        .DEPTH(DEPTH)
    ) u_occupancy (
        .clk_i     (clk_i),
        .rsn_i     (rsn_i),
        .inc_i     (alloc_acc),
        .dec_i     (retire_acc | flush_pull),
        .count_o   (count),
        .empty_o   (empty),
        .full_o    (full),
        .exp_full_o(exp_full)
    );

    // Ready comes from registered state/count only; a same-cycle retire never frees a slot.
    assign alloc_ready_o = (state_q == ST_RUN) && !full;
    assign alloc_acc     = alloc_valid_i && alloc_ready_o;
    assign retire_acc    = (state_q == ST_RUN) && retire_req_i && !empty;

`ifdef SVC_FLUSH_EN
    assign flush_pull = (state_q == ST_FLUSH) && !empty;
`else
    assign flush_pull = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
`ifdef SVC_FLUSH_EN
                if (flush_i) state_d = ST_FLUSH;
`endif
            end
`ifdef SVC_FLUSH_EN
            // Leave on the edge that retires the last entry so DRAIN sees count 0.
            ST_FLUSH: if (count <= CNT_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_RUN;
`endif
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= ST_INIT;
            push_q  <= 1'b0;
            pull_q  <= 1'b0;
            value_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            push_q  <= alloc_acc;
            pull_q  <= retire_acc | flush_pull;
            value_q <= alloc_acc & alloc_value_i;
            ack_q   <= retire_acc;
            err_q   <= err_q | ((state_q == ST_RUN) && (full_i != exp_full));
        end
    end

    assign retire_ack_o = ack_q;
    assign push_o       = push_q;
    assign pull_o       = pull_q;
    assign value_o      = value_q;
    assign count_o      = count;
    assign empty_o      = empty;
    assign full_o       = full;
    assign busy_o       = (state_q != ST_RUN);
    assign err_o        = err_q;

endmodule

// File: tb/tb_status_vector_ctrl.sv
// Self-checking bench for status_vector_ctrl against a transaction-level model.
module tb_status_vector_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef SVC_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif
    // {ready, ack, push, pull, value, empty, full, busy, err}
    localparam logic [8:0] RESET_FLAGS = 9'b0_0_0_0_0_1_0_1_0;

    logic          clk_i = 1'b0;
    logic          rsn_i = 1'b0;
    logic          alloc_valid_i = 1'b0;
    logic          alloc_value_i = 1'b0;
    logic          retire_req_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          full_i = 1'b0;
    logic          alloc_ready_o, retire_ack_o, push_o, pull_o, value_o;
    logic          empty_o, full_o, busy_o, err_o;
    logic [CW-1:0] count_o;
    logic [8:0]    dut_flags;

    int checks = 0;
    int failures = 0;

    // Model: mode 0=INIT 1=RUN 2=FLUSH 3=DRAIN, occupancy as a plain integer.
    int m_mode, m_count;
    bit m_push, m_pull, m_val, m_ack, m_exp_full, m_err, force_full;

    status_vector_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .alloc_valid_i(alloc_valid_i),
        .alloc_value_i(alloc_value_i),
        .alloc_ready_o(alloc_ready_o),
        .retire_req_i (retire_req_i),
        .retire_ack_o (retire_ack_o),
`ifdef SVC_FLUSH_EN
        .flush_i      (flush_i),
`endif
        .full_i       (full_i),
        .push_o       (push_o),
        .pull_o       (pull_o),
        .value_o      (value_o),
        .count_o      (count_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    assign dut_flags = {alloc_ready_o, retire_ack_o, push_o, pull_o, value_o,
                        empty_o, full_o, busy_o, err_o};

    function automatic logic [8:0] exp_flags();
        return {(m_mode == 1) && (m_count < DEPTH), m_ack, m_push, m_pull, m_val,
                m_count == 0, m_count == DEPTH, m_mode != 1, m_err};
    endfunction

    task automatic model_clear();
        m_mode = 0; m_count = 0; m_push = 0; m_pull = 0; m_val = 0;
        m_ack = 0; m_exp_full = 0; m_err = 0; force_full = 0;
    endtask

    // One clock: drive inputs, advance model on the edge, settle 1 time unit.
    task automatic step(input bit a, input bit v, input bit r, input bit f);
        bit acc, ret, fp, err_n;
        alloc_valid_i = a; alloc_value_i = v; retire_req_i = r; flush_i = f;
        full_i = force_full ? 1'b1 : m_exp_full;
        acc   = a && (m_mode == 1) && (m_count < DEPTH);
        ret   = r && (m_mode == 1) && (m_count > 0);
        fp    = (m_mode == 2) && (m_count > 0);
        err_n = m_err || ((m_mode == 1) && (full_i != m_exp_full));
        @(posedge clk_i);
        m_push = acc; m_val = acc && v; m_ack = ret; m_pull = ret || fp;
        m_exp_full = (m_count == DEPTH); m_err = err_n;
        case (m_mode)
            0: m_mode = 1;
            1: if (f && FLUSH_EN) m_mode = 2;
            2: if (m_count <= 1) m_mode = 3;
            default: m_mode = 1;
        endcase
        m_count = m_count + int'(acc) - int'(ret) - int'(fp);
        #1;
    endtask

    task automatic do_reset();
        alloc_valid_i = 0; alloc_value_i = 0; retire_req_i = 0; flush_i = 0; full_i = 0;
        rsn_i = 0;
        model_clear();
        #1;
        @(posedge clk_i);
        #1;
        rsn_i = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_flags !== RESET_FLAGS || count_o !== '0) begin
            failures++;
            $display("FAIL reset_values: got flags=%b count=%0d expected flags=%b count=0",
                     dut_flags, count_o, RESET_FLAGS);
        end
        step(0, 0, 0, 0);
        checks++;
        if (busy_o !== 1'b0 || alloc_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL init_exit: got busy=%b ready=%b expected busy=0 ready=1", busy_o, alloc_ready_o);
        end
    endtask

    task automatic test_basic_alloc();
        bit vals [3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        step(0, 0, 0, 0);
        foreach (vals[i]) begin
            step(1, vals[i], 0, 0);
            checks++;
            if (push_o !== 1'b1 || value_o !== vals[i]) begin
                failures++;
                $display("FAIL basic_push%0d: got push=%b value=%b expected push=1 value=%b",
                         i, push_o, value_o, vals[i]);
            end
        end
        step(0, 0, 0, 0);
        checks++;
        if (push_o !== 1'b0 || count_o !== CW'(3)) begin
            failures++;
            $display("FAIL basic_count: got push=%b count=%0d expected push=0 count=3", push_o, count_o);
        end
    endtask

    task automatic test_fill();
        int pushes = 0;
        do_reset();
        step(0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(1, 1'($urandom), 0, 0);
            if (push_o === 1'b1) pushes++;
            checks++;
            if (dut_flags !== exp_flags() || count_o !== CW'(m_count)) begin
                failures++;
                $display("FAIL fill_cycle%0d: got flags=%b count=%0d expected flags=%b count=%0d",
                         k, dut_flags, count_o, exp_flags(), m_count);
            end
        end
        checks++;
        if (pushes != DEPTH || full_o !== 1'b1 || alloc_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL fill_total: got pushes=%0d full=%b ready=%b expected pushes=%0d full=1 ready=0",
                     pushes, full_o, alloc_ready_o, DEPTH);
        end
    endtask

    task automatic test_full_alloc_retire();
        step(1, 1, 1, 0);
        checks++;
        if (retire_ack_o !== 1'b1 || pull_o !== 1'b1 || push_o !== 1'b0 || count_o !== CW'(DEPTH - 1)) begin
            failures++;
            $display("FAIL full_both: got ack=%b pull=%b push=%b count=%0d expected ack=1 pull=1 push=0 count=%0d",
                     retire_ack_o, pull_o, push_o, count_o, DEPTH - 1);
        end
        step(1, 0, 0, 0);
        checks++;
        if (push_o !== 1'b1 || count_o !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL full_refill: got push=%b count=%0d expected push=1 count=%0d", push_o, count_o, DEPTH);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        checks++;
        if (push_o !== 1'b1 || pull_o !== 1'b1 || retire_ack_o !== 1'b1 || count_o !== CW'(5)) begin
            failures++;
            $display("FAIL simultaneous: got push=%b pull=%b ack=%b count=%0d expected 1 1 1 count=5",
                     push_o, pull_o, retire_ack_o, count_o);
        end
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic test_empty_retire();
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        checks++;
        if (retire_ack_o !== 1'b0 || pull_o !== 1'b0 || err_o !== 1'b0 || count_o !== '0) begin
            failures++;
            $display("FAIL empty_retire: got ack=%b pull=%b err=%b count=%0d expected 0 0 0 count=0",
                     retire_ack_o, pull_o, err_o, count_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 40) == 0));
            checks++;
            if (dut_flags !== exp_flags() || count_o !== CW'(m_count)) begin
                failures++;
                $display("FAIL random_cycle%0d: got flags=%b count=%0d expected flags=%b count=%0d",
                         k, dut_flags, count_o, exp_flags(), m_count);
            end
        end
    endtask

`ifdef SVC_FLUSH_EN
    task automatic test_flush();
        int pulls = 0;
        int drains = 0;
        do_reset();
        step(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
        step(0, 0, 0, 1);
        for (int k = 0; k < 12; k++) begin
            if (busy_o === 1'b1 && count_o === '0) drains++;
            step(1, 1, 1, 1);
            if (pull_o === 1'b1) pulls++;
            if (busy_o !== 1'b1) break;
            checks++;
            if (alloc_ready_o !== 1'b0 || retire_ack_o !== 1'b0) begin
                failures++;
                $display("FAIL flush_blocked%0d: got ready=%b ack=%b expected 0 0", k, alloc_ready_o, retire_ack_o);
            end
        end
        checks++;
        if (pulls != 4 || drains != 1 || busy_o !== 1'b0 || count_o !== '0) begin
            failures++;
            $display("FAIL flush_done: got pulls=%0d drains=%0d busy=%b count=%0d expected 4 1 busy=0 count=0",
                     pulls, drains, busy_o, count_o);
        end
    endtask
`endif

    task automatic test_err();
        do_reset();
        step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0);
        force_full = 1;
        step(0, 0, 0, 0);
        force_full = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (err_o !== 1'b1) begin
                failures++;
                $display("FAIL err_sticky%0d: got err=%b expected 1", k, err_o);
            end
            step(1'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        rsn_i = 0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_reset: got err=%b expected 0", err_o);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(1, 1, 0, 0);
        step(1, 1, 0, FLUSH_EN);
        step(0, 0, 0, 0);
        #2;
        rsn_i = 0;
        #1;
        checks++;
        if (dut_flags !== RESET_FLAGS || count_o !== '0) begin
            failures++;
            $display("FAIL reset_mid: got flags=%b count=%0d expected flags=%b count=0",
                     dut_flags, count_o, RESET_FLAGS);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic_alloc();
        test_fill();
        test_full_alloc_retire();
        test_simultaneous();
        test_empty_retire();
        test_random();
`ifdef SVC_FLUSH_EN
        test_flush();
`endif
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
